// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencing controller for a D-flip-flop shift-register datapath. A WIDTH-bit
// word is accepted over a valid/ready handshake, loaded into an internal shift
// register and presented one bit at a time on sout. Each bit is held until the
// consumer strobes adv. After the last bit is consumed, done pulses for one
// cycle. A new word may be accepted in that same done cycle, which gives
// back-to-back frames separated by a single gap cycle.
//
// Parameters:
//   WIDTH     - word length in bits (2..32)
//   CW        - bit-counter width, 2**CW must exceed WIDTH
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   cl         in   clock, all state changes on the rising edge
//   res        in   synchronous reset, active-high, overrides every input
//   din        in   parallel word, held stable while din_valid is pending
//   din_valid  in   producer offers a word
//   din_ready  out  controller accepts a word on this edge if din_valid=1
//   adv        in   consumer took the current bit, move to the next one
//   sout       out  current serial bit (0 outside a frame)
//   sout_en    out  sout carries a valid frame bit
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last bit was consumed
//   bit_cnt    out  index of the bit currently on sout
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CW        = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             cl,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             adv,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             sout_q;
    logic             sout_en_q;
    logic             busy_q;
    logic             done_q;
    logic             din_ready_q;

    // Shift register contents after one advance: move toward the output end
    // and fill the vacated position with zero.
    logic [WIDTH-1:0] shreg_shift_d;

    assign shreg_shift_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    // Bit of a word that sits at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // NOTE: every output is a flop loaded with the value it must show in the
    // next state, so no input reaches an output combinationally.
    // NOTE: state is written with non-blocking assignments only, so every
    // branch below reads the values from before the edge.
    always_ff @(posedge cl) begin
        if (res) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sout_q      <= 1'b0;
            sout_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (din_valid) begin
                        // Load the word; its first bit is visible next cycle.
                        state_q     <= ST_SHIFT;
                        shreg_q     <= din;
                        bit_cnt_q   <= '0;
                        sout_q      <= out_bit(din);
                        sout_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        din_ready_q <= 1'b0;
                    end else begin
                        state_q     <= ST_IDLE;
                        sout_q      <= 1'b0;
                        sout_en_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        din_ready_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (adv) begin
                        if (bit_cnt_q == LAST_IDX) begin
                            // Last bit consumed: keep shreg/bit_cnt, pulse done.
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            sout_q      <= 1'b0;
                            sout_en_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            din_ready_q <= 1'b1;
                        end else begin
                            shreg_q   <= shreg_shift_d;
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                            sout_q    <= out_bit(shreg_shift_d);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sout_q      <= 1'b0;
                    sout_en_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    din_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign din_ready = din_ready_q;
    assign sout      = sout_q;
    assign sout_en   = sout_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Bench for shift_seq_ctrl. An MSB-first instance is exercised by a vector
// table, directed multi-cycle sequences and random traffic compared against a
// bit-queue reference model. A second, LSB-first instance covers bit order and
// the ignored-din_valid-during-frame case.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 5;

    logic cl = 1'b0;
    always #5 cl = ~cl;

    // MSB-first instance
    logic          res, din_valid, adv;
    logic [W-1:0]  din;
    logic          din_ready, sout, sout_en, busy, done;
    logic [CW-1:0] bit_cnt;

    // LSB-first instance
    logic          l_res, l_din_valid, l_adv;
    logic [W-1:0]  l_din;
    logic          l_din_ready, l_sout, l_sout_en, l_busy, l_done;
    logic [CW-1:0] l_bit_cnt;

    shift_seq_ctrl #(.WIDTH(W), .CW(CW), .MSB_FIRST(1'b1)) u_msb (
        .cl(cl), .res(res), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .adv(adv), .sout(sout), .sout_en(sout_en),
        .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    shift_seq_ctrl #(.WIDTH(W), .CW(CW), .MSB_FIRST(1'b0)) u_lsb (
        .cl(cl), .res(l_res), .din(l_din), .din_valid(l_din_valid),
        .din_ready(l_din_ready), .adv(l_adv), .sout(l_sout), .sout_en(l_sout_en),
        .busy(l_busy), .done(l_done), .bit_cnt(l_bit_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Reference model: a frame is the queue of bits still to be consumed,
    // in transmission order. Empty queue means no frame in progress.
    // ---------------------------------------------------------------------
    bit q_bits[$];
    bit m_done;

    function automatic void model_edge(input bit r, input bit dv,
                                       input logic [W-1:0] d, input bit a);
        if (r) begin
            q_bits.delete();
            m_done = 1'b0;
        end else if (q_bits.size() != 0) begin
            m_done = 1'b0;
            if (a) begin
                void'(q_bits.pop_front());
                if (q_bits.size() == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (dv) for (int i = 0; i < W; i++) q_bits.push_back(d[W-1-i]);
        end
    endfunction

    task automatic compare_model(input string tag);
        bit in_frame;
        in_frame = (q_bits.size() != 0);
        check({tag, ".sout"},      32'(sout),      in_frame ? 32'(q_bits[0]) : 32'd0);
        check({tag, ".sout_en"},   32'(sout_en),   32'(in_frame));
        check({tag, ".busy"},      32'(busy),      32'(in_frame));
        check({tag, ".din_ready"}, 32'(din_ready), 32'(!in_frame));
        check({tag, ".done"},      32'(done),      32'(m_done));
        if (in_frame) check({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(W - q_bits.size()));
    endtask

    // One clock: model follows the inputs present at the edge, outputs are
    // compared 1 time unit later.
    task automatic step(input string tag);
        @(posedge cl);
        model_edge(res, din_valid, din, adv);
        #1;
        compare_model(tag);
    endtask

    // ---------------------------------------------------------------------
    // Vector table
    // ---------------------------------------------------------------------
    typedef struct {
        bit           res;
        bit           dv;
        logic [W-1:0] din;
        bit           adv;
        bit           e_sout;
        bit           e_en;
        bit           e_busy;
        bit           e_done;
        bit           e_rdy;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [15:0] stream;
        logic [7:0]  seq;
        int          n_done;
        int          adv_cnt;
        bit          prev;

        // res, dv, din, adv | sout, en, busy, done, rdy, cnt
        tbl[0]  = '{1, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 0};  // reset with dv/adv high
        tbl[1]  = '{1, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0};  // idle after release
        tbl[3]  = '{0, 1, 8'hA5, 1, 1, 1, 1, 0, 0, 0};  // accept: bit0
        tbl[4]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 1};
        tbl[5]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 2};
        tbl[6]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 3};
        tbl[7]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 4};
        tbl[8]  = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 5};
        tbl[9]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 0, 6};
        tbl[10] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 7};
        tbl[11] = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 7};  // done cycle
        tbl[12] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 7};  // back to idle

        res = 1'b1; din_valid = 1'b0; adv = 1'b0; din = '0;
        l_res = 1'b1; l_din_valid = 1'b0; l_adv = 1'b0; l_din = '0;

        #1;
        for (int i = 0; i < 13; i++) begin
            res = tbl[i].res; din_valid = tbl[i].dv; din = tbl[i].din; adv = tbl[i].adv;
            @(posedge cl);
            model_edge(res, din_valid, din, adv);
            #1;
            check($sformatf("tbl%0d.sout", i),      32'(sout),      32'(tbl[i].e_sout));
            check($sformatf("tbl%0d.sout_en", i),   32'(sout_en),   32'(tbl[i].e_en));
            check($sformatf("tbl%0d.busy", i),      32'(busy),      32'(tbl[i].e_busy));
            check($sformatf("tbl%0d.done", i),      32'(done),      32'(tbl[i].e_done));
            check($sformatf("tbl%0d.din_ready", i), 32'(din_ready), 32'(tbl[i].e_rdy));
            if (i < 3 || tbl[i].e_en)
                check($sformatf("tbl%0d.bit_cnt", i), 32'(bit_cnt), 32'(tbl[i].e_cnt));
        end
        adv = 1'b0;

        // Back-to-back frames: 3C then C3 with din_valid held high.
        stream = '0; n_done = 0;
        din = 8'h3C; din_valid = 1'b1; adv = 1'b1;
        for (int s = 0; s < 20; s++) begin
            step("b2b");
            if (s == 0) din = 8'hC3;
            if (s == 9) din_valid = 1'b0;
            if (sout_en) stream = {stream[14:0], sout};
            if (done) n_done++;
            if (s == 8) check("b2b.gap_sout_en", 32'(sout_en), 32'd0);
            if (s == 9) check("b2b.second_accepted", 32'(busy), 32'd1);
        end
        check("b2b.stream", 32'(stream), 32'h3CC3);
        check("b2b.done_pulses", 32'(n_done), 32'd2);
        adv = 1'b0;

        // Throttling: adv only every third cycle.
        din = 8'hA5; din_valid = 1'b1;
        step("thr_load");
        din_valid = 1'b0;
        adv_cnt = 0; seq = '0;
        for (int c = 0; c < 24; c++) begin
            adv = (c % 3 == 2);
            prev = sout;
            if (adv) begin
                adv_cnt++;
                seq = {seq[6:0], sout};
            end
            step("thr");
            if (adv_cnt < 8) begin
                check("thr.sout_en", 32'(sout_en), 32'd1);
                if (!adv) check("thr.hold", 32'(sout), 32'(prev));
            end else begin
                check("thr.done_after_8th", 32'(done), 32'd1);
            end
        end
        check("thr.bits", 32'(seq), 32'hA5);
        adv = 1'b0;
        step("thr_idle");

        // Mid-frame reset after three bits of FF.
        din = 8'hFF; din_valid = 1'b1; adv = 1'b1;
        step("mid_load");
        din_valid = 1'b0;
        step("mid_b1");
        step("mid_b2");
        res = 1'b1;
        step("mid_res");
        check("mid.sout_en", 32'(sout_en), 32'd0);
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.bit_cnt", 32'(bit_cnt), 32'd0);
        res = 1'b0;
        step("mid_after");
        check("mid.no_done", 32'(done), 32'd0);
        din = 8'h01; din_valid = 1'b1;
        step("mid_new_load");
        din_valid = 1'b0;
        seq = {7'd0, sout};
        for (int i = 1; i < 8; i++) begin
            step("mid_new");
            seq = {seq[6:0], sout};
        end
        check("mid.new_bits", 32'(seq), 32'h01);
        step("mid_new_done");
        check("mid.new_done", 32'(done), 32'd1);
        adv = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            res       = ($urandom_range(0, 99) == 0);
            adv       = ($urandom_range(0, 9) < 6);
            if (!din_valid || !din_ready) begin
                din_valid = ($urandom_range(0, 1) == 1);
                din       = W'($urandom);
            end
            step("rnd");
        end
        res = 1'b0; din_valid = 1'b0; adv = 1'b0;

        // LSB-first instance: 01 goes out as 1,0,0,0,0,0,0,0.
        @(posedge cl); #1;
        l_res = 1'b0;
        l_din = 8'h01; l_din_valid = 1'b1; l_adv = 1'b1;
        @(posedge cl); #1;
        l_din_valid = 1'b0;
        check("lsb.busy", 32'(l_busy), 32'd1);
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], l_sout};
            check("lsb.sout_en", 32'(l_sout_en), 32'd1);
            check("lsb.din_ready", 32'(l_din_ready), 32'd0);
            l_din_valid = (i == 3);
            if (i == 3) l_din = 8'hFF;
            @(posedge cl); #1;
        end
        l_din_valid = 1'b0;
        check("lsb.bits", 32'(seq), 32'h80);
        check("lsb.done", 32'(l_done), 32'd1);
        @(posedge cl); #1;
        check("lsb.idle_after", 32'(l_busy), 32'd0);
        check("lsb.no_extra_done", 32'(l_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
